gpio_in_capture: RTL and testbench
==================================

// Module: gpio_in_capture
// PURPOSE
// Input-side counterpart of the pipeline's GPIO output path: samples external GPIO input pins,
// synchronizes and debounces them, and presents a stable word to the EX stage on a read request.
// Sits between board switch/pin inputs and the datapath register-write mux.
// Pipeline reads GPIO via a one-cycle read strobe; a sticky change flag tells software new data exists.
// PARAMETERS
// WIDTH            32  width of GPIO input word
// DEBOUNCE_CYCLES  16  consecutive stable synced cycles required before accepting a new value (>=2)
// CNT_W            $clog2(DEBOUNCE_CYCLES+1)  counter width (derived, do not override)
// PORTS
// clk           in   1      system clock
// rst           in   1      asynchronous reset, active-high
// GPIO_IN       in   WIDTH  raw external pins, asynchronous to clk
// gpio_rd_en    in   1      read strobe from EX-stage control (one cycle per read)
// gpio_rd_data  out  WIDTH  snapshot of debounced value, valid when gpio_rd_valid=1
// gpio_rd_valid out  1      one-cycle pulse, cycle after gpio_rd_en
// gpio_changed  out  1      sticky: debounced value changed since last read
// gpio_stable   out  WIDTH  current debounced value (live, for debug/LEDs)
// gpio_irq      out  1      change interrupt (see CONFIGURATION)
// BEHAVIOUR
// - Clock is clk, reset is rst: one clock domain, rst asynchronous and active-high.
// - Reset: sync1, sync2, cand, stable, gpio_rd_data = 0; cnt = 0; gpio_rd_valid, gpio_changed, gpio_irq = 0.
// - Sync: 2-FF chain, sync1<=GPIO_IN, sync2<=sync1. Nothing downstream sees GPIO_IN directly.
// - Debounce (whole word, not per bit), evaluated each posedge:
//   * sync2 != cand: cand<=sync2, cnt<=0 (any bit toggling restarts window).
//   * sync2 == cand and cnt < DEBOUNCE_CYCLES: cnt<=cnt+1; cnt saturates at DEBOUNCE_CYCLES.
//   * accept edge: sync2==cand and cnt==DEBOUNCE_CYCLES-1: if cand != stable, stable<=cand and set change.
// - Latency: pin change stable from before edge 1 -> stable updated at edge 3+DEBOUNCE_CYCLES
//   (19 cycles at default). Glitch shorter than DEBOUNCE_CYCLES synced cycles never reaches stable.
// - Return to old value within window: cand follows, window restarts; no change flagged if value == stable.
// - Read handshake: gpio_rd_en at edge N -> gpio_rd_data<=stable (value before edge N), gpio_rd_valid=1
//   for the cycle after edge N; gpio_rd_valid low otherwise. Back-to-back strobes give back-to-back pulses.
// - gpio_changed: set on accept edge with a changed value; cleared by gpio_rd_en.
//   Simultaneous set and clear: set wins (read returns old value, flag stays up for next read).
// - gpio_rd_data holds last snapshot between reads.
// - Reset mid-window or mid-read: all state to reset values immediately; no pulse emitted after release.
// - All arithmetic unsigned; cnt never wraps.
// CONFIGURATION
// GPIO_IN_IRQ_EN defined: adds input gpio_irq_mask (WIDTH); gpio_irq registered,
//   set on accept edge when ((cand ^ stable) & gpio_irq_mask) != 0, cleared by gpio_rd_en (set wins).
//   gpio_irq_mask resets-independent (input); mask change does not retro-fire.
// GPIO_IN_IRQ_EN undefined: no gpio_irq_mask port; gpio_irq tied 0.
// TESTING
// 1. Reset: assert rst mid-run with GPIO_IN=32'hFFFF -> all outputs 0 during and 1 cycle after release.
// 2. GPIO_IN 0->32'h0000_00A5 held -> gpio_stable=32'hA5 and gpio_changed=1 exactly 19 cycles later.
// 3. 10-cycle pulse of 32'h1 then back to 0 -> gpio_stable stays 0, gpio_changed stays 0.
// 4. After change to 32'hA5, pulse gpio_rd_en -> next cycle gpio_rd_valid=1, gpio_rd_data=32'hA5, changed=0.
// 5. gpio_rd_en on same edge as accept of 32'h3C (old 32'hA5) -> rd_data=32'hA5, gpio_changed stays 1.
// 6. GPIO_IN_IRQ_EN, mask=32'h1: change bit 4 only -> gpio_irq=0; change bit 0 -> gpio_irq=1 until read.

Source files
------------

// File: rtl/gpio_in_capture_if.sv
// Read-side bus between the EX stage and the GPIO input capture block.
// Signals: gpio_rd_en (strobe), gpio_rd_data/gpio_rd_valid (snapshot), gpio_changed, gpio_irq.
interface gpio_in_capture_if #(
    parameter int WIDTH = 32
);
    logic             gpio_rd_en;
    logic [WIDTH-1:0] gpio_rd_data;
    logic             gpio_rd_valid;
    logic             gpio_changed;
    logic             gpio_irq;

    modport master (
        output gpio_rd_en,
        input  gpio_rd_data,
        input  gpio_rd_valid,
        input  gpio_changed,
        input  gpio_irq
    );

    modport slave (
        input  gpio_rd_en,
        output gpio_rd_data,
        output gpio_rd_valid,
        output gpio_changed,
        output gpio_irq
    );
endinterface

// File: rtl/gpio_in_capture.sv
// GPIO input capture: 2-FF sync, whole-word debounce, read snapshot, sticky change flag.
// Ports: clk, rst (async high), GPIO_IN raw pins, gpio_stable live value, bus = read interface.
// Macro GPIO_IN_IRQ_EN adds gpio_irq_mask and a masked change interrupt; otherwise gpio_irq is 0.
module gpio_in_capture #(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 16,
    localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] GPIO_IN,
`ifdef GPIO_IN_IRQ_EN
    input  logic [WIDTH-1:0] gpio_irq_mask,
`endif
    output logic [WIDTH-1:0] gpio_stable,
    gpio_in_capture_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] stable;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             changed;

    logic             match;
    logic             accept;
    logic [WIDTH-1:0] delta;
    logic             accept_chg;

    assign match      = (sync2 == cand);
    // Last cycle of the window: cnt reaches DEBOUNCE_CYCLES on this edge.
    assign accept     = match && (cnt == CNT_LAST);
    assign delta      = cand ^ stable;
    assign accept_chg = accept && (|delta);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            cand     <= '0;
            stable   <= '0;
            cnt      <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            changed  <= 1'b0;
        end else begin
            sync1 <= GPIO_IN;
            sync2 <= sync1;

            // Any bit moving restarts the window for the whole word.
            if (!match) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            if (accept_chg) begin
                stable <= cand;
            end

            rd_valid <= bus.gpio_rd_en;
            if (bus.gpio_rd_en) begin
                rd_data <= stable;
            end

            // Set beats clear so a change racing a read is not lost.
            if (accept_chg) begin
                changed <= 1'b1;
            end else if (bus.gpio_rd_en) begin
                changed <= 1'b0;
            end
        end
    end

`ifdef GPIO_IN_IRQ_EN
    logic irq;
    logic irq_set;

    assign irq_set = accept && (|(delta & gpio_irq_mask));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else if (irq_set) begin
            irq <= 1'b1;
        end else if (bus.gpio_rd_en) begin
            irq <= 1'b0;
        end
    end

    assign bus.gpio_irq = irq;
`else
    assign bus.gpio_irq = 1'b0;
`endif

    assign gpio_stable       = stable;
    assign bus.gpio_rd_data  = rd_data;
    assign bus.gpio_rd_valid = rd_valid;
    assign bus.gpio_changed  = changed;

endmodule

// File: tb/tb_gpio_in_capture.sv
// Self-checking bench for gpio_in_capture: directed vectors, read scoreboard.
// Expected read data is queued at strobe time and checked by a monitor on gpio_rd_valid.
module tb_gpio_in_capture;

    localparam int W = 32;

`ifdef GPIO_IN_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [W-1:0]  gpio_in;
    logic [W-1:0]  gpio_stable;
`ifdef GPIO_IN_IRQ_EN
    logic [W-1:0]  gpio_irq_mask;
`endif

    gpio_in_capture_if #(.WIDTH(W)) bus ();

    gpio_in_capture #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .GPIO_IN(gpio_in),
`ifdef GPIO_IN_IRQ_EN
        .gpio_irq_mask(gpio_irq_mask),
`endif
        .gpio_stable(gpio_stable),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one read strobe and queue the value it must return.
    task automatic rd(input logic [W-1:0] exp);
        bus.gpio_rd_en = 1'b1;
        exp_q.push_back(exp);
        tick();
        bus.gpio_rd_en = 1'b0;
    endtask

    // Monitor: every valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.gpio_rd_valid) begin
            checks++;
            if (rst || exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: rd_valid=1 data=%h with no read pending", bus.gpio_rd_data);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (bus.gpio_rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data: got %h expected %h at %0t", bus.gpio_rd_data, e, $time);
                end
            end
        end
    end

    task automatic chk_all_zero(input string name);
        chk({name, "_stable"}, gpio_stable, '0);
        chk({name, "_rd_data"}, bus.gpio_rd_data, '0);
        chk({name, "_rd_valid"}, W'(bus.gpio_rd_valid), '0);
        chk({name, "_changed"}, W'(bus.gpio_changed), '0);
        chk({name, "_irq"}, W'(bus.gpio_irq), '0);
    endtask

    initial begin
        rst = 1'b1;
        gpio_in = '0;
        bus.gpio_rd_en = 1'b0;
`ifdef GPIO_IN_IRQ_EN
        gpio_irq_mask = 32'h1;
`endif
        tick(2);
        chk_all_zero("por");
        rst = 1'b0;
        tick(20);

        // Glitches shorter than the window never reach stable.
        gpio_in = 32'h1;
        tick(10);
        gpio_in = '0;
        tick(30);
        chk("glitch10_stable", gpio_stable, 32'h0);
        chk("glitch10_changed", W'(bus.gpio_changed), 32'h0);
        gpio_in = 32'h1;
        tick(15);
        gpio_in = '0;
        tick(30);
        chk("glitch15_stable", gpio_stable, 32'h0);
        chk("glitch15_changed", W'(bus.gpio_changed), 32'h0);

        // Change accepted exactly 19 edges after the pin moves.
        gpio_in = 32'h0000_00A5;
        tick(18);
        chk("lat18_stable", gpio_stable, 32'h0);
        chk("lat18_changed", W'(bus.gpio_changed), 32'h0);
        tick();
        chk("lat19_stable", gpio_stable, 32'hA5);
        chk("lat19_changed", W'(bus.gpio_changed), 32'h1);

        // Read clears changed; back-to-back strobes give two pulses.
        rd(32'hA5);
        chk("rd_clr_changed", W'(bus.gpio_changed), 32'h0);
        rd(32'hA5);
        rd(32'hA5);
        tick(3);
        chk("rd_hold_data", bus.gpio_rd_data, 32'hA5);
        chk("rd_valid_low", W'(bus.gpio_rd_valid), 32'h0);

        // Read on the accept edge: old value returned, flag survives.
        gpio_in = 32'h0000_003C;
        tick(18);
        chk("race_pre_stable", gpio_stable, 32'hA5);
        rd(32'hA5);
        chk("race_stable", gpio_stable, 32'h3C);
        chk("race_changed", W'(bus.gpio_changed), 32'h1);
        rd(32'h3C);
        chk("race_clr_changed", W'(bus.gpio_changed), 32'h0);

        // Bit 4 only (masked out), then bit 0 (unmasked when irq built in).
        gpio_in = 32'h0000_002C;
        tick(19);
        chk("b4_stable", gpio_stable, 32'h2C);
        chk("b4_changed", W'(bus.gpio_changed), 32'h1);
        chk("b4_irq", W'(bus.gpio_irq), 32'h0);
        rd(32'h2C);
        gpio_in = 32'h0000_002D;
        tick(19);
        chk("b0_stable", gpio_stable, 32'h2D);
        chk("b0_irq", W'(bus.gpio_irq), W'(IRQ_ON));
        tick(3);
        chk("b0_irq_hold", W'(bus.gpio_irq), W'(IRQ_ON));
        rd(32'h2D);
        chk("b0_irq_clr", W'(bus.gpio_irq), 32'h0);
        chk("b0_changed_clr", W'(bus.gpio_changed), 32'h0);

        // Return to the accepted value inside the window: nothing flagged.
        gpio_in = 32'h0000_00FF;
        tick(8);
        gpio_in = 32'h0000_002D;
        tick(30);
        chk("ret_stable", gpio_stable, 32'h2D);
        chk("ret_changed", W'(bus.gpio_changed), 32'h0);

        // Asynchronous reset mid-window with a read strobe in flight.
        gpio_in = 32'h0000_FFFF;
        tick(5);
        bus.gpio_rd_en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        tick(2);
        chk_all_zero("rst_held");
        rst = 1'b0;
        bus.gpio_rd_en = 1'b0;
        tick();
        chk_all_zero("rst_after");
        tick(3);
        chk("rst_after_valid", W'(bus.gpio_rd_valid), 32'h0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_reads: got %0d outstanding expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
